// File: rtl/pipe_stage_chain.sv
// Reusable chain of pipeline registers with valid/ready handshake,
// per-stage hold, partial flush of younger stages and a stall counter.
module pipe_stage_chain #(
    parameter int                 STAGES      = 4,
    parameter int                 DATA_W      = 96,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0,
    parameter int                 CNT_W       = 32,
    localparam int                OCC_W       = $clog2(STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic [STAGES-1:0]          hold,
    input  logic                       flush_en,
    input  logic [OCC_W-1:0]           flush_cnt,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*DATA_W-1:0]   stage_data,
    output logic [OCC_W-1:0]           occupancy,
    output logic [CNT_W-1:0]           stall_cnt,
    input  logic                       stall_cnt_clr
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [STAGES-1:0] src_valid;
    logic [DATA_W-1:0] src_data [STAGES];
    logic [STAGES:0]   rdy;
    logic [OCC_W-1:0]  fc;
    logic [OCC_W-1:0]  occ_d;
    logic              stall;

    // Ready ripples from the oldest stage back to the input.
    always_comb begin
        logic r;
        r = out_ready;
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r = !hold[i] && (!valid_q[i] || r);
            rdy[i] = r;
        end
    end

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = valid_q[i-1] && !hold[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    assign fc = flush_en ? flush_cnt : '0;

    always_comb begin
        stall = 1'b0;
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
            if (OCC_W'(i) < fc) begin
                valid_d[i] = 1'b0;
                data_d[i]  = BUBBLE_DATA;
            end else if (hold[i]) begin
                stall = stall | valid_q[i];
            end else if (src_valid[i] && rdy[i]) begin
                // Entry leaving the last flushed stage dies on the way.
                if (fc != '0 && OCC_W'(i) == fc) begin
                    valid_d[i] = 1'b0;
                    data_d[i]  = BUBBLE_DATA;
                end else begin
                    valid_d[i] = 1'b1;
                    data_d[i]  = src_data[i];
                end
            end else if (rdy[i+1]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = BUBBLE_DATA;
            end
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            occupancy <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= BUBBLE_DATA;
            end
        end else begin
            valid_q   <= valid_d;
            occupancy <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
            if (stall_cnt_clr) begin
                stall_cnt <= '0;
            end else if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*DATA_W +: DATA_W] = data_q[i];
        end
    end

    assign in_ready    = rdy[0];
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign stage_valid = valid_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus random traffic,
// every cycle compared against a stage-array reference model.
module tb_pipe_stage_chain;

    localparam int S   = 4;
    localparam int DW  = 16;
    localparam int CW  = 4;
    localparam int OW  = $clog2(S + 1);
    localparam logic [DW-1:0] BUB = 16'hA5C3;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [S-1:0]    hold;
    logic            flush_en;
    logic [OW-1:0]   flush_cnt;
    logic [S-1:0]    stage_valid;
    logic [S*DW-1:0] stage_data;
    logic [OW-1:0]   occupancy;
    logic [CW-1:0]   stall_cnt;
    logic            stall_cnt_clr;

    pipe_stage_chain #(
        .STAGES(S), .DATA_W(DW), .BUBBLE_DATA(BUB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .hold(hold), .flush_en(flush_en), .flush_cnt(flush_cnt),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt),
        .stall_cnt_clr(stall_cnt_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_bad;

    // Reference model state
    bit          mv [S];
    logic [DW-1:0] md [S];
    int          mc;
    bit          last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            md[i] = BUB;
        end
        mc = 0;
    endtask

    task automatic check_state();
        logic [S-1:0]    v;
        logic [S*DW-1:0] d;
        for (int i = 0; i < S; i++) begin
            v[i] = mv[i];
            d[i*DW +: DW] = md[i];
        end
        chk("stage_valid", stage_valid, v);
        chk("stage_data", stage_data, d);
        chk("out_valid", out_valid, v[S-1]);
        chk("out_data", out_data, md[S-1]);
        chk("occupancy", occupancy, $countones(v));
        chk("stall_cnt", stall_cnt, mc);
    endtask

    // One clock: check in_ready, predict next state, clock, compare.
    task automatic step();
        bit            r [S+1];
        bit            nv [S];
        logic [DW-1:0] nd [S];
        bit            sv;
        logic [DW-1:0] sd;
        int            fc;
        bit            st;
        #1;
        r[S] = out_ready;
        for (int i = S - 1; i >= 0; i--)
            r[i] = !hold[i] && (!mv[i] || r[i+1]);
        chk("in_ready", in_ready, r[0]);
        last_rdy = r[0];
        fc = flush_en ? int'(flush_cnt) : 0;
        st = 1'b0;
        for (int i = 0; i < S; i++) begin
            nv[i] = mv[i];
            nd[i] = md[i];
            if (i == 0) begin
                sv = in_valid;
                sd = in_data;
            end else begin
                sv = mv[i-1] && !hold[i-1];
                sd = md[i-1];
            end
            if (i >= fc && hold[i] && mv[i]) st = 1'b1;
            if (i < fc) begin
                nv[i] = 1'b0; nd[i] = BUB;
            end else if (hold[i]) begin
                nv[i] = mv[i];
            end else if (sv && r[i]) begin
                if (fc > 0 && i == fc) begin
                    nv[i] = 1'b0; nd[i] = BUB;
                end else begin
                    nv[i] = 1'b1; nd[i] = sd;
                end
            end else if (r[i+1]) begin
                nv[i] = 1'b0; nd[i] = BUB;
            end
        end
        if (stall_cnt_clr) mc = 0;
        else if (st && mc < (1 << CW) - 1) mc++;
        @(posedge clk);
        for (int i = 0; i < S; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
        #1;
        check_state();
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        hold = '0; flush_en = 1'b0; flush_cnt = '0; stall_cnt_clr = 1'b0;
    endtask

    initial begin
        int base;
        logic [DW-1:0] seq;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_state();
        rst = 1'b1;

        // Stream: back-to-back 1,2,3...
        seq = 16'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = seq; seq++;
            step();
        end
        chk("stream_first_out", {out_valid, out_data}, {1'b1, 16'd1});
        for (int k = 0; k < 6; k++) begin
            in_data = seq; seq++;
            step();
        end
        chk("stream_occ", occupancy, 4);
        chk("stream_seq", out_data, 16'd7);

        // Drain, then backpressure with continuous input
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (last_rdy || k == 0) begin
                in_data = seq; seq++;
            end
            step();
        end
        chk("bp_full", stage_valid, 4'b1111);
        chk("bp_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (last_rdy) begin
                in_data = seq; seq++;
            end
            step();
        end

        // Hold stage 1 for two cycles mid-stream
        stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
        base = int'(stall_cnt);
        hold = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            if (last_rdy) begin
                in_data = seq; seq++;
            end
            step();
        end
        chk("hold_stall2", stall_cnt, base + 2);
        chk("hold_bubble", stage_data[2*DW +: DW], BUB);
        hold = '0;
        for (int k = 0; k < 4; k++) begin
            if (last_rdy) begin
                in_data = seq; seq++;
            end
            step();
        end

        // Flush two youngest while full and blocked
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (last_rdy) begin
                in_data = seq; seq++;
            end
            step();
        end
        flush_en = 1'b1; flush_cnt = 3'd2; in_data = seq; seq++;
        step();
        chk("flush2_valid", stage_valid, 4'b1100);
        chk("flush2_data", stage_data[2*DW-1:0], {BUB, BUB});
        flush_en = 1'b0; flush_cnt = '0;
        for (int k = 0; k < 2; k++) begin
            in_data = seq; seq++;
            step();
        end

        // Flush everything while every stage is held
        base = int'(stall_cnt);
        hold = 4'b1111; flush_en = 1'b1; flush_cnt = 3'd4;
        step();
        chk("flushall_valid", stage_valid, 4'b0000);
        chk("flushall_stall", stall_cnt, base);
        hold = '0; flush_en = 1'b0; flush_cnt = '0;

        // Saturating stall counter, then clear
        stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data = seq; seq++;
            step();
        end
        hold = 4'b1111;
        for (int k = 0; k < 20; k++) step();
        chk("stall_sat", stall_cnt, 4'd15);
        stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
        chk("stall_clr", stall_cnt, 4'd0);
        hold = '0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = seq; seq++;
            step();
        end

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", stage_valid, 4'b0000);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_occ", occupancy, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_data", stage_data, {4{BUB}});
        @(posedge clk);
        #1;
        check_state();
        rst = 1'b1;
        idle_inputs();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 16'd100 + 16'(k);
            step();
        end
        chk("restart_lat", {out_valid, out_data}, {1'b1, 16'd100});

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            if (!(in_valid && !last_rdy)) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = 16'($urandom);
            end
            out_ready     = ($urandom % 3) != 0;
            hold          = (($urandom % 8) == 0) ? 4'($urandom) : 4'b0000;
            flush_en      = ($urandom % 16) == 0;
            flush_cnt     = 3'($urandom_range(0, 4));
            stall_cnt_clr = ($urandom % 32) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
